// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - FIFO-fed note scheduler driving the sound generator period
//
// Purpose: the CPU pushes (period, duration) notes into a DEPTH-entry FIFO;
// the block plays them back-to-back on `period` (0 = silence).
// Optional feature: define SEQ_GAP_EN to insert GAP_MS of silence after
// every played note (including the last).
//
// Ports:
//   clk          clock (clk12 domain)
//   reset        asynchronous active-low reset
//   note_wr      push strobe, one note per high cycle
//   note_period  tone period of the pushed note (0 = rest)
//   note_dur_ms  length of the pushed note in ms
//   stop         synchronous flush of FIFO, state and overflow flag
//   period       registered period to the sound generator
//   busy         high while a note or a gap is being timed
//   full         FIFO holds DEPTH entries
//   level        FIFO occupancy
//   overflow     sticky, set when a push is dropped because the FIFO is full
module tone_sequencer #(
  parameter int DEPTH        = 8,
  parameter int TICKS_PER_MS = 12500,
  parameter int GAP_MS       = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   note_wr,
  input  logic [31:0]            note_period,
  input  logic [15:0]            note_dur_ms,
  input  logic                   stop,
  output logic [31:0]            period,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MS - 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TICKS_PER_MS < 1 || GAP_MS < 1) begin : g_param_check
    $error("tone_sequencer: invalid parameter set");
  end

`ifdef SEQ_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;
`else
  typedef enum logic {S_IDLE, S_PLAY} state_e;
`endif

  state_e          state_q, state_d;
  logic [31:0]     period_q, period_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     ms_left_q, ms_left_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [47:0]     mem_q [DEPTH];

  logic            full_q;
  logic            push, pop, try_pop;
  logic [31:0]     head_period;
  logic [15:0]     head_dur;

  assign full_q      = (count_q == LW'(DEPTH));
  assign head_period = mem_q[rd_ptr_q][31:0];
  assign head_dur    = mem_q[rd_ptr_q][47:32];

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    presc_d    = presc_q;
    ms_left_d  = ms_left_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    try_pop    = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        period_d = '0;
        try_pop  = 1'b1;
      end
      S_PLAY: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          // Test for the last ms before decrementing so ms_left never wraps.
          if (ms_left_q > 16'd1) begin
            ms_left_d = ms_left_q - 16'd1;
          end else begin
            period_d = '0;
`ifdef SEQ_GAP_EN
            state_d   = S_GAP;
            ms_left_d = 16'(GAP_MS);
`else
            // Next note (if any) is popped at this same edge: no silent cycle.
            state_d   = S_IDLE;
            ms_left_d = '0;
            try_pop   = 1'b1;
`endif
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
`ifdef SEQ_GAP_EN
      S_GAP: begin
        if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (ms_left_q > 16'd1) begin
            ms_left_d = ms_left_q - 16'd1;
          end else begin
            state_d   = S_IDLE;
            ms_left_d = '0;
            try_pop   = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d  = S_IDLE;
        period_d = '0;
      end
    endcase

    if (try_pop && count_q != '0) begin
      pop       = 1'b1;
      presc_d   = '0;
      ms_left_d = head_dur;
      if (head_dur != 16'd0) begin
        state_d  = S_PLAY;
        period_d = head_period;
      end else begin
        // Zero-length notes are discarded without ever reaching `period`.
        state_d  = S_IDLE;
        period_d = '0;
      end
    end

    // Full is the registered flag, so a same-cycle pop cannot rescue a push.
    if (note_wr) begin
      if (full_q) overflow_d = 1'b1;
      else        push       = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    if (stop) begin
      push       = 1'b0;
      state_d    = S_IDLE;
      period_d   = '0;
      presc_d    = '0;
      ms_left_d  = '0;
      overflow_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      period_q   <= '0;
      presc_q    <= '0;
      ms_left_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      ms_left_q  <= ms_left_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {note_dur_ms, note_period};
  end

  assign period   = period_q;
  assign busy     = (state_q != S_IDLE);
  assign full     = full_q;
  assign level    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - self-checking bench for tone_sequencer
module tb_tone_sequencer;

  localparam int DEPTH  = 4;
  localparam int TPM    = 4;
  localparam int GAP_MS = 2;
`ifdef SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        note_wr;
  logic [31:0] note_period;
  logic [15:0] note_dur_ms;
  logic        stop;
  logic [31:0] period;
  logic        busy;
  logic        full;
  logic [2:0]  level;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.DEPTH(DEPTH), .TICKS_PER_MS(TPM), .GAP_MS(GAP_MS)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .note_wr     (note_wr),
    .note_period (note_period),
    .note_dur_ms (note_dur_ms),
    .stop        (stop),
    .period      (period),
    .busy        (busy),
    .full        (full),
    .level       (level),
    .overflow    (overflow)
  );

  // Reference model: a note queue plus a count of output cycles left in the
  // current note or gap (mode 0 idle, 1 playing, 2 gap).
  typedef struct {
    logic [31:0] p;
    logic [15:0] d;
  } note_t;

  note_t       mq[$];
  int          m_mode;
  int          m_left;
  logic [31:0] m_period;
  bit          m_over;

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_left = 0;
    m_period = 32'd0;
    m_over = 1'b0;
  endtask

  task automatic model_step();
    note_t n;
    bit    can_pop;
    bit    was_full;
    if (stop) begin
      model_reset();
      return;
    end
    was_full = (mq.size() == DEPTH);
    can_pop  = (m_mode == 0);
    if (m_mode != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_period = 32'd0;
        if (m_mode == 1 && GAP_ON) begin
          m_mode = 2;
          m_left = GAP_MS * TPM;
        end else begin
          m_mode  = 0;
          can_pop = 1'b1;
        end
      end
    end
    if (can_pop && mq.size() > 0) begin
      n = mq.pop_front();
      if (n.d != 16'd0) begin
        m_mode   = 1;
        m_left   = int'(n.d) * TPM;
        m_period = n.p;
      end else begin
        m_mode   = 0;
        m_period = 32'd0;
      end
    end
    if (note_wr) begin
      if (was_full) m_over = 1'b1;
      else begin
        n.p = note_period;
        n.d = note_dur_ms;
        mq.push_back(n);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_period", period, m_period);
    chk("model_busy", 32'(busy), 32'(m_mode != 0));
    chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
    chk("model_level", 32'(level), 32'(mq.size()));
    chk("model_overflow", 32'(overflow), 32'(m_over));
  endtask

  task automatic drive(input bit wr, input logic [31:0] p, input logic [15:0] d, input bit st);
    note_wr = wr;
    note_period = p;
    note_dur_ms = d;
    stop = st;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] p;
    logic [15:0] d;
    bit          st;
    logic [31:0] e_per;
    bit          e_busy;
    logic [2:0]  e_lvl;
    bit          e_full;
    bit          e_ovf;
  } vec_t;

  function automatic vec_t mkv(bit wr, logic [31:0] p, logic [15:0] d, bit st,
                               logic [31:0] ep, bit eb, logic [2:0] el, bit ef, bit eo);
    vec_t v;
    v.wr = wr; v.p = p; v.d = d; v.st = st;
    v.e_per = ep; v.e_busy = eb; v.e_lvl = el; v.e_full = ef; v.e_ovf = eo;
    return v;
  endfunction

  vec_t        tbl[16];
  logic [31:0] ew[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Inputs during the cycle, then outputs expected right after its edge.
    tbl[0]  = mkv(1'b1, 32'd1000, 16'd3, 1'b0, 32'd0,    1'b0, 3'd1, 1'b0, 1'b0);
    tbl[1]  = mkv(1'b1, 32'd500,  16'd3, 1'b0, 32'd1000, 1'b1, 3'd1, 1'b0, 1'b0);
    tbl[2]  = mkv(1'b1, 32'd600,  16'd3, 1'b0, 32'd1000, 1'b1, 3'd2, 1'b0, 1'b0);
    tbl[3]  = mkv(1'b1, 32'd700,  16'd3, 1'b0, 32'd1000, 1'b1, 3'd3, 1'b0, 1'b0);
    tbl[4]  = mkv(1'b1, 32'd800,  16'd3, 1'b0, 32'd1000, 1'b1, 3'd4, 1'b1, 1'b0);
    tbl[5]  = mkv(1'b1, 32'd900,  16'd3, 1'b0, 32'd1000, 1'b1, 3'd4, 1'b1, 1'b1);
    tbl[6]  = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd1000, 1'b1, 3'd4, 1'b1, 1'b1);
    tbl[7]  = mkv(1'b1, 32'd111,  16'd3, 1'b1, 32'd0,    1'b0, 3'd0, 1'b0, 1'b0);
    tbl[8]  = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd0,    1'b0, 3'd0, 1'b0, 1'b0);
    tbl[9]  = mkv(1'b1, 32'd900,  16'd0, 1'b0, 32'd0,    1'b0, 3'd1, 1'b0, 1'b0);
    tbl[10] = mkv(1'b1, 32'd300,  16'd1, 1'b0, 32'd0,    1'b0, 3'd1, 1'b0, 1'b0);
    tbl[11] = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd300,  1'b1, 3'd0, 1'b0, 1'b0);
    tbl[12] = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd300,  1'b1, 3'd0, 1'b0, 1'b0);
    tbl[13] = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd300,  1'b1, 3'd0, 1'b0, 1'b0);
    tbl[14] = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd300,  1'b1, 3'd0, 1'b0, 1'b0);
    tbl[15] = mkv(1'b0, 32'd0,    16'd0, 1'b0, 32'd0,    GAP_ON, 3'd0, 1'b0, 1'b0);

    drive(1'b0, 32'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;

    chk("reset_period", period, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);

    // Table: fill to full, overflow, stop-with-write, zero-duration discard.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].wr, tbl[i].p, tbl[i].d, tbl[i].st);
      tick();
      chk($sformatf("tbl%0d_period", i), period, tbl[i].e_per);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
    end
    drive(1'b0, 32'd0, 16'd0, 1'b0);
    repeat (12) tick();

    // Single note: 12 cycles of 1000 starting two edges after the push.
    drive(1'b1, 32'd1000, 16'd3, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      drive(1'b0, 32'd0, 16'd0, 1'b0);
      chk($sformatf("single_period_e%0d", k), period, (k >= 2 && k <= 13) ? 32'd1000 : 32'd0);
      chk($sformatf("single_busy_e%0d", k), 32'(busy),
          32'((k >= 2 && k <= 13) || (GAP_ON && k >= 14)));
    end
    repeat (12) tick();

    // Back-to-back notes: no silent cycle unless gaps are enabled.
    ew.delete();
    ew.push_back(32'd0);
    repeat (4) ew.push_back(32'd500);
    if (GAP_ON) repeat (GAP_MS * TPM) ew.push_back(32'd0);
    repeat (8) ew.push_back(32'd700);
    while (ew.size() < 32) ew.push_back(32'd0);
    drive(1'b1, 32'd500, 16'd1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1) drive(1'b1, 32'd700, 16'd2, 1'b0);
      else        drive(1'b0, 32'd0, 16'd0, 1'b0);
      chk($sformatf("b2b_period_e%0d", k), period, ew[k-1]);
    end
    repeat (12) tick();

    // Asynchronous reset between edges silences the output immediately.
    drive(1'b1, 32'd1000, 16'd3, 1'b0);
    tick();
    drive(1'b0, 32'd0, 16'd0, 1'b0);
    repeat (3) tick();
    chk("pre_reset_period", period, 32'd1000);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_period", period, 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_level", 32'(level), 32'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'd400, 16'd2, 1'b0);
    tick();
    drive(1'b0, 32'd0, 16'd0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      check_model();
      tick();
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 2000; k++) begin
      drive($urandom_range(0, 2) == 0,
            ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 5000)),
            16'($urandom_range(0, 3)),
            $urandom_range(0, 149) == 0);
      tick();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Memory-mapped note scheduler that sequences the period input of the sound generator.
- The CPU pushes (period, duration) notes into a small FIFO through memIO.
- The block plays the notes back-to-back and drives `period`, where 0 means silence.
- Runs on clk12. `period` feeds the sound module through the existing 32-bit period wire.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, ≥2).
- TICKS_PER_MS, 12500, clk cycles per millisecond (≥1).
- GAP_MS, 10, silence between notes when SEQ_GAP_EN is defined (≥1).

Ports:
- clk  input  1  clock (clk12 domain).
- reset  input  1  asynchronous, active-low reset.
- note_wr  input  1  push strobe, one note per high cycle.
- note_period  input  32  tone period; 0 = rest.
- note_dur_ms  input  16  note length in ms.
- stop  input  1  synchronous flush.
- period  output  32  to the sound generator; registered.
- busy  output  1  high in PLAY or GAP.
- full  output  1  FIFO count == DEPTH.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; state IDLE.
  - period=0, busy=0, full=0, level=0, overflow=0.
  - Prescaler and ms counter cleared.
- FIFO write:
  - note_wr=1 and full=0 → entry stored, level+1 next cycle.
  - note_wr=1 and full=1 → write dropped, overflow←1. full is the registered flag; a same-cycle pop does not rescue the write.
- States IDLE, PLAY, GAP. Pop occurs only on the transitions marked "pop".
- IDLE:
  - period=0.
  - If level≠0 → pop. Load cur_period and ms_left=note_dur_ms; period←cur_period at the same edge.
  - If the popped dur≠0 → PLAY. If dur==0 → note discarded, stay IDLE, period stays 0.
  - Latency: a write into an empty idle FIFO at edge N gives period valid after edge N+2.
- PLAY:
  - Prescaler counts 0..TICKS_PER_MS-1.
  - At wrap, ms_left decrements.
  - A note occupies exactly dur×TICKS_PER_MS cycles of period output.
- At note end:
  - With SEQ_GAP_EN: → GAP.
  - Without SEQ_GAP_EN, level≠0: pop next note; period switches at the same edge with no silent cycle; dur==0 entries → IDLE.
  - Without SEQ_GAP_EN, level==0: → IDLE, period←0.
- GAP:
  - period=0 for GAP_MS×TICKS_PER_MS cycles.
  - Then behaves as IDLE: pops the next note if present, else stays IDLE.
- busy=1 in PLAY and GAP.
- Simultaneous pop and write with full=0: both performed, level unchanged.
- stop=1:
  - At the next edge: FIFO flushed, state IDLE, period=0, overflow cleared, counters cleared.
  - Priority over note_wr in the same cycle (write dropped, overflow not set).
- reset asserted mid-note → immediate silence; all state as reset.
- Wrap-around: FIFO pointers wrap modulo DEPTH. ms_left is 16 bits and never underflows; the 0 check happens before decrement.
- Counter widths:
  - Prescaler is $clog2(TICKS_PER_MS) bits (min 1).
  - Max note length is 65535 ms.

Optional Feature:
- Macro SEQ_GAP_EN.
- Defined: a GAP_MS silence is inserted after every played note, including the last.
- Undefined: GAP state absent; notes are back-to-back and GAP_MS is unused.

Test Plan (TICKS_PER_MS=4, DEPTH=4, GAP_MS=2 for simulation):
- Reset, push (period=1000, dur=3) → period=1000 for exactly 12 cycles starting 2 edges after the write; then 0; busy follows.
- Push (500,1), (700,2) back-to-back without gap → period 500 for 4 cycles, then 700 for 8 cycles with no 0 cycle in between, then 0. With SEQ_GAP_EN: 8 cycles of 0 between the notes and after the last.
- Push 5 notes while the first plays with DEPTH=4 → level reaches 4, full=1, overflow=1 on the 5th (or 6th, per pop timing). The dropped note never plays.
- Push (900,0) then (300,1) → 900 never appears on period; 300 plays for 4 cycles.
- Mid-note, assert stop together with note_wr → period=0 next cycle, level=0, overflow=0, busy=0; the written note is absent.
- Mid-note, pulse reset=0 asynchronously between edges → period=0 immediately; after release, a new push plays normally.
